// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 5-stage pipeline. Owns the PC register,
//   presents it to instruction memory, and captures {pc, instruction, pc+4}
//   into the IF/ID pipeline register for the decode stage.
//
//   Each clock edge applies the highest-priority case that holds:
//     redirect > stall > out_of_range > normal fetch.
//   A redirect loads the branch target and flushes IF/ID to a bubble.
//   A stall freezes the PC and IF/ID.
//   An out-of-range PC parks the stage. It inserts bubbles until a redirect
//   arrives.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous active-low reset
//   stall         hold PC and IF/ID this cycle
//   redirect      load redirect_pc and flush IF/ID
//   redirect_pc   branch target; bits [1:0] are dropped, nonzero sets
//                 misalign_err
//   imem_addr     instruction memory address (= current PC)
//   imem_rdata    instruction at imem_addr, valid in the same cycle
//   if_id_valid   IF/ID holds a real instruction
//   if_id_instr   IF/ID instruction (NOP_INSTR on a bubble)
//   if_id_pc      PC of the IF/ID instruction
//   if_id_pc4     if_id_pc + 4, the link value for BL
//   out_of_range  PC is at or beyond the end of instruction memory
//   misalign_err  sticky flag, set when a misaligned redirect was accepted
//   fetch_cnt     saturating count of valid instructions captured
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter logic [31:0] NOP_INSTR  = 32'hD503201F,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [63:0]      redirect_pc,
    output logic [63:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic             if_id_valid,
    output logic [31:0]      if_id_instr,
    output logic [63:0]      if_id_pc,
    output logic [63:0]      if_id_pc4,
    output logic             out_of_range,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_cnt
);

    // First byte address past the end of instruction memory.
    localparam logic [63:0] PC_LIMIT = 64'(IMEM_WORDS) << 2;

    // The fetch mode is derived from the PC rather than stored. A redirect
    // to an in-range target is therefore the only way out of HALT.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_mode_e;

    logic [63:0]      pc_q,      pc_d;
    logic             valid_q,   valid_d;
    logic [31:0]      instr_q,   instr_d;
    logic [63:0]      ifpc_q,    ifpc_d;
    logic [63:0]      ifpc4_q,   ifpc4_d;
    logic             misal_q,   misal_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    fetch_mode_e      mode;
    logic [63:0]      pc_plus4;

    assign mode     = (pc_q >= PC_LIMIT) ? HALT : RUN;
    // Wraps modulo 2^64 by construction.
    assign pc_plus4 = pc_q + 64'd4;

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        misal_d = misal_q;
        cnt_d   = cnt_q;

        if (redirect) begin
            // Overrides a simultaneous stall. The instruction held in IF/ID
            // is on the wrong path, so it is replaced by a bubble. The
            // bubble keeps the old pc/pc4 fields.
            pc_d    = {redirect_pc[63:2], 2'b00};
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (redirect_pc[1:0] != 2'b00) begin
                misal_d = 1'b1;
            end
        end else if (stall) begin
            // Every register holds.
        end else begin
            case (mode)
                HALT: begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
                default: begin
                    valid_d = 1'b1;
                    instr_d = imem_rdata;
                    ifpc_d  = pc_q;
                    ifpc4_d = pc_plus4;
                    pc_d    = pc_plus4;
                    if (!(&cnt_q)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            ifpc_q  <= 64'h0;
            ifpc4_q <= 64'h0;
            misal_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            misal_q <= misal_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr    = pc_q;
    assign out_of_range = (mode == HALT);
    assign if_id_valid  = valid_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc     = ifpc_q;
    assign if_id_pc4    = ifpc4_q;
    assign misalign_err = misal_q;
    assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Drives two fetch_stage instances:
//     A: default parameters (1024-word memory, 32-bit counter)
//     B: 4-word memory, 2-bit counter
//   The instruction memory is modelled as word i = 0x100 + i. Both instances
//   are compared every cycle against a behavioural reference model. Directed
//   steps run first, followed by a randomized stall/redirect/reset phase.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'hD503201F;
    localparam logic [63:0] LIM_A  = 64'd4096;
    localparam logic [63:0] LIM_B  = 64'd16;
    localparam logic [63:0] CMAX_A = 64'hFFFF_FFFF;
    localparam logic [63:0] CMAX_B = 64'd3;

    typedef struct packed {
        logic [63:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [63:0] ipc;
        logic [63:0] ipc4;
        logic        mis;
        logic [63:0] cnt;
    } mdl_t;

    logic        clk;
    logic        rst;

    logic        a_stall, a_redir;
    logic [63:0] a_rpc, a_addr, a_ipc, a_ipc4;
    logic [31:0] a_rdata, a_instr, a_cnt;
    logic        a_valid, a_oor, a_mis;

    logic        b_stall, b_redir;
    logic [63:0] b_rpc, b_addr, b_ipc, b_ipc4;
    logic [31:0] b_rdata, b_instr;
    logic [1:0]  b_cnt;
    logic        b_valid, b_oor, b_mis;

    mdl_t ma, mb;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic logic [31:0] imem_word(logic [63:0] addr);
        return 32'h100 + 32'(addr / 64'd4);
    endfunction

    assign a_rdata = imem_word(a_addr);
    assign b_rdata = imem_word(b_addr);

    fetch_stage u_a (
        .clk(clk), .rst(rst), .stall(a_stall), .redirect(a_redir), .redirect_pc(a_rpc),
        .imem_addr(a_addr), .imem_rdata(a_rdata), .if_id_valid(a_valid),
        .if_id_instr(a_instr), .if_id_pc(a_ipc), .if_id_pc4(a_ipc4),
        .out_of_range(a_oor), .misalign_err(a_mis), .fetch_cnt(a_cnt)
    );

    fetch_stage #(.IMEM_WORDS(4), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .stall(b_stall), .redirect(b_redir), .redirect_pc(b_rpc),
        .imem_addr(b_addr), .imem_rdata(b_rdata), .if_id_valid(b_valid),
        .if_id_instr(b_instr), .if_id_pc(b_ipc), .if_id_pc4(b_ipc4),
        .out_of_range(b_oor), .misalign_err(b_mis), .fetch_cnt(b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.pc    = 64'h0;
        s.valid = 1'b0;
        s.instr = NOP;
        s.ipc   = 64'h0;
        s.ipc4  = 64'h0;
        s.mis   = 1'b0;
        s.cnt   = 64'h0;
        return s;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, logic st, logic rd, logic [63:0] rpc,
                                      logic [63:0] limit, logic [63:0] cmax);
        mdl_t n = s;
        if (rd) begin
            n.pc    = rpc - (rpc % 64'd4);
            n.valid = 1'b0;
            n.instr = NOP;
            if (rpc % 64'd4 != 64'd0) n.mis = 1'b1;
        end else if (st) begin
            n = s;
        end else if (s.pc >= limit) begin
            n.valid = 1'b0;
            n.instr = NOP;
        end else begin
            n.valid = 1'b1;
            n.instr = imem_word(s.pc);
            n.ipc   = s.pc;
            n.ipc4  = s.pc + 64'd4;
            n.pc    = s.pc + 64'd4;
            if (s.cnt < cmax) n.cnt = s.cnt + 64'd1;
        end
        return n;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("a_imem_addr",   a_addr,          ma.pc);
        chk("a_out_of_range", 64'(a_oor),     64'(ma.pc >= LIM_A));
        chk("a_valid",       64'(a_valid),    64'(ma.valid));
        chk("a_instr",       64'(a_instr),    64'(ma.instr));
        chk("a_if_id_pc",    a_ipc,           ma.ipc);
        chk("a_if_id_pc4",   a_ipc4,          ma.ipc4);
        chk("a_misalign",    64'(a_mis),      64'(ma.mis));
        chk("a_fetch_cnt",   64'(a_cnt),      ma.cnt);
        chk("b_imem_addr",   b_addr,          mb.pc);
        chk("b_out_of_range", 64'(b_oor),     64'(mb.pc >= LIM_B));
        chk("b_valid",       64'(b_valid),    64'(mb.valid));
        chk("b_instr",       64'(b_instr),    64'(mb.instr));
        chk("b_if_id_pc",    b_ipc,           mb.ipc);
        chk("b_if_id_pc4",   b_ipc4,          mb.ipc4);
        chk("b_misalign",    64'(b_mis),      64'(mb.mis));
        chk("b_fetch_cnt",   64'(b_cnt),      mb.cnt);
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        ma = mdl_step(ma, a_stall, a_redir, a_rpc, LIM_A, CMAX_A);
        mb = mdl_step(mb, b_stall, b_redir, b_rpc, LIM_B, CMAX_B);
        #1;
        cyc++;
        check_all();
        $display("cyc %0d A pc=%0h v=%0b ipc=%0h ins=%0h cnt=%0d | B pc=%0h v=%0b oor=%0b cnt=%0d",
                 cyc, a_addr, a_valid, a_ipc, a_instr, a_cnt, b_addr, b_valid, b_oor, b_cnt);
    endtask

    task automatic set_a(input logic st, input logic rd, input logic [63:0] rpc);
        a_stall = st; a_redir = rd; a_rpc = rpc;
    endtask

    task automatic set_b(input logic st, input logic rd, input logic [63:0] rpc);
        b_stall = st; b_redir = rd; b_rpc = rpc;
    endtask

    // Called just after a rising edge: pulse reset between edges and check
    // that state clears without waiting for a clock.
    task automatic async_reset();
        #3 rst = 1'b0;
        #1;
        ma = mdl_reset();
        mb = mdl_reset();
        check_all();
        $display("async reset at cycle %0d", cyc);
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        set_a(1'b0, 1'b0, 64'h0);
        set_b(1'b0, 1'b0, 64'h0);
        ma = mdl_reset();
        mb = mdl_reset();
        #1 rst = 1'b0;
        #1 check_all();
        chk("rst_instr_nop", 64'(a_instr), 64'(NOP));
        #1 rst = 1'b1;

        // Free run: four fetches; B reaches the end of its 4-word memory.
        repeat (4) step();
        chk("t1_cnt",      64'(a_cnt),   64'd4);
        chk("t1_ipc",      a_ipc,        64'hC);
        chk("t1_instr",    64'(a_instr), 64'h103);
        chk("t5_b_oor",    64'(b_oor),   64'd1);
        chk("t5_b_addr",   b_addr,       64'd16);
        chk("t6_b_cnt_sat", 64'(b_cnt),  64'd3);

        // Stall A for three cycles; B keeps inserting bubbles.
        set_a(1'b1, 1'b0, 64'h0);
        repeat (3) step();
        chk("t2_ipc_hold", a_ipc,        64'hC);
        chk("t2_pc_hold",  a_addr,       64'h10);
        chk("t2_cnt_hold", 64'(a_cnt),   64'd4);
        chk("t5_b_bubble", 64'(b_valid), 64'd0);
        chk("t5_b_pc_hold", b_addr,      64'd16);
        set_a(1'b0, 1'b0, 64'h0);
        step();
        chk("t2_resume",   a_ipc,        64'h10);

        // Redirect with a simultaneous stall; B leaves HALT via a redirect.
        set_a(1'b1, 1'b1, 64'h40);
        set_b(1'b0, 1'b1, 64'h0);
        step();
        chk("t3_pc",       a_addr,       64'h40);
        chk("t3_flush_v",  64'(a_valid), 64'd0);
        chk("t3_flush_i",  64'(a_instr), 64'(NOP));
        chk("t5_b_run",    64'(b_oor),   64'd0);
        set_a(1'b0, 1'b0, 64'h0);
        set_b(1'b0, 1'b0, 64'h0);
        step();
        chk("t3_ipc",      a_ipc,        64'h40);
        chk("t3_instr",    64'(a_instr), 64'h110);
        chk("t5_b_fetch",  64'(b_valid), 64'd1);

        // Misaligned redirect sets the sticky error flag.
        set_a(1'b0, 1'b1, 64'h42);
        step();
        chk("t4_pc_align", a_addr,       64'h40);
        chk("t4_mis",      64'(a_mis),   64'd1);
        set_a(1'b0, 1'b1, 64'h80);
        step();
        chk("t4_mis_sticky", 64'(a_mis), 64'd1);
        chk("t4_pc",       a_addr,       64'h80);

        // Bring A to pc 0x20, then reset between edges.
        set_a(1'b0, 1'b1, 64'h18);
        step();
        set_a(1'b0, 1'b0, 64'h0);
        repeat (2) step();
        chk("t6_pre_pc",   a_addr,       64'h20);
        async_reset();
        chk("t6_rst_pc",   a_addr,       64'h0);
        chk("t6_rst_cnt",  64'(a_cnt),   64'd0);
        chk("t6_rst_v",    64'(a_valid), 64'd0);

        // Redirect on the first edge after reset.
        set_a(1'b0, 1'b1, 64'h10);
        step();
        chk("first_redir_pc",  a_addr,       64'h10);
        chk("first_redir_v",   64'(a_valid), 64'd0);
        chk("first_redir_cnt", 64'(a_cnt),   64'd0);
        set_a(1'b0, 1'b0, 64'h0);
        repeat (5) step();
        chk("t6_b_sat",    64'(b_cnt),   64'd3);

        // Randomized phase.
        for (int i = 0; i < 800; i++) begin
            a_stall = ($urandom_range(0, 3) == 0);
            a_redir = ($urandom_range(0, 7) == 0);
            a_rpc   = 64'($urandom_range(0, 1100)) * 64'd4
                      + (($urandom_range(0, 5) == 0) ? 64'($urandom_range(1, 3)) : 64'd0);
            b_stall = ($urandom_range(0, 3) == 0);
            b_redir = ($urandom_range(0, 5) == 0);
            b_rpc   = 64'($urandom_range(0, 5)) * 64'd4
                      + (($urandom_range(0, 7) == 0) ? 64'($urandom_range(1, 3)) : 64'd0);
            step();
            if ($urandom_range(0, 63) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
